pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program counter and instruction fetch stage for the single-cycle-style MIPS core.
- Holds the PC and fetches from a variable-latency instruction memory using a req/ready handshake.
- Presents the fetched instruction to the decoder/control unit, then advances the PC when the instruction retires.
- The advance uses the control unit's Pcsrc (sequential, branch or jump), plus the sign-extended immediate and the jump field.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Clrn  in  1  asynchronous, active-low reset.
- Pcsrc  in  2  next-PC select from control unit: 00 seq, 01 jump, 10 branch, 11 treated as jump.
- Ext_imm  in  32  sign-extended 16-bit immediate of the current instruction.
- Jaddr  in  26  jump target field, Inst[25:0].
- Stall  in  1  high blocks retirement of the held instruction.
- Inst_ack  in  1  current instruction has completed; PC may advance.
- Imem_req  out  1  fetch request to instruction memory.
- Imem_addr  out  32  fetch address; always equals Pc.
- Imem_ready  in  1  memory returns Imem_rdata this cycle.
- Imem_rdata  in  32  fetched instruction word.
- Inst  out  32  held instruction, feeding Op/Func/rs/rt/rd/imm decode.
- Inst_valid  out  1  Inst is valid and being executed.
- Pc  out  32  current PC.
- Pc4  out  32  Pc + 4, for link/branch use.

Behaviour:
- Reset (Clrn=0, asynchronous, may occur at any time including mid-fetch):
  - Pc=RESET_PC, Inst=0, Inst_valid=0, state=IDLE, Imem_req=0.
  - An Imem_ready arriving during reset is ignored.
- States:
  - IDLE: always moves to FETCH on the next edge. Imem_req=0.
  - FETCH: Imem_req=1, Imem_addr=Pc. On Imem_ready=1: Inst<=Imem_rdata, Inst_valid<=1, go to HOLD. Otherwise stay; Pc and Imem_addr are held stable.
  - HOLD: Imem_req=0, Inst and Inst_valid held.
    - If Inst_ack=1 and Stall=0: Pc<=next_pc, Inst_valid<=0, go to FETCH.
    - If Stall=1: Inst_ack is ignored and the unit stays in HOLD.
- Outputs:
  - Imem_req and Inst_valid are Moore outputs; no combinational path from Imem_ready to Imem_req.
  - Latency is at least 1 cycle from ack to the next request.
  - Imem_ready in the same cycle FETCH is entered is accepted.
- next_pc (combinational; all adds are modulo 2^32, overflow wraps silently):
  - seq: Pc4.
  - branch: Pc4 + {Ext_imm[29:0], 2'b00}.
  - jump: {Pc4[31:28], Jaddr, 2'b00}.
- Decode inputs: Pcsrc, Ext_imm and Jaddr are sampled only on the retiring edge (HOLD & Inst_ack & ~Stall). They are don't-care otherwise.
- Wrap-around: Pc=32'hFFFF_FFFC with seq gives 32'h0000_0000.
- Imem_ready outside FETCH is ignored.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - Cnt_retired (32 bit): increments on every retiring edge.
  - Cnt_redirect (32 bit): increments on retiring edges with Pcsrc != 00.
- Both counters reset to 0 on Clrn and wrap at 2^32.
- When not defined, the ports and logic are absent and the module behaves identically otherwise.

Decomposition:
- Shared package cpu_pkg holds:
  - Pcsrc encoding constants PCSRC_SEQ=2'b00, PCSRC_JUMP=2'b01, PCSRC_BRANCH=2'b10.
  - Fetch state encoding FS_IDLE/FS_FETCH/FS_HOLD.
  - Word width constant 32.
- One sub-module: next_pc_calc, purely combinational. Inputs Pc4, Ext_imm, Jaddr, Pcsrc; output next_pc.

Test Plan:
- Reset then Imem_ready=1 on the first FETCH cycle with rdata 32'h2008_0005 -> Imem_req rises 1 cycle after reset release; Imem_addr=0; Inst=32'h2008_0005 and Inst_valid=1 next cycle.
- Sequential retire: Pcsrc=00, Inst_ack=1 at Pc=0 -> Pc=4, Inst_valid=0, Imem_req=1 the following cycle.
- Branch: Pc=32'h10, Ext_imm=32'hFFFF_FFFE, Pcsrc=10, ack -> Pc=32'h0C. Jump: Pc=32'h4000_0000, Jaddr=26'h000_0040, Pcsrc=01 -> Pc=32'h4000_0100.
- Memory latency 3 cycles: Imem_req held high with a stable address for 3 cycles. Stall=1 with Inst_ack=1 for 2 cycles -> Pc unchanged; advance only after Stall drops.
- Clrn asserted mid-FETCH and mid-HOLD -> outputs go to reset values immediately, without a clock edge. Pc=32'hFFFF_FFFC seq retire -> Pc=0.
- With FETCH_PERF_CNT_EN: 5 retires, 2 of them redirected -> Cnt_retired=5, Cnt_redirect=2.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants for the MIPS core: word width, Pcsrc encoding, fetch states.
package cpu_pkg;

    localparam int WORD_W  = 32;
    localparam int JADDR_W = 26;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'b00,
        FS_FETCH = 2'b01,
        FS_HOLD  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select: sequential, branch (Pc4 + imm<<2) or jump.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0]  Pc4,
    input  logic [WORD_W-1:0]  Ext_imm,
    input  logic [JADDR_W-1:0] Jaddr,
    input  logic [1:0]         Pcsrc,
    output logic [WORD_W-1:0]  next_pc
);

    logic [WORD_W-1:0] br_target;
    logic [WORD_W-1:0] j_target;
    logic              unused_imm_hi;

    // The top two immediate bits fall off the word shift.
    assign unused_imm_hi = ^Ext_imm[WORD_W-1:WORD_W-2];
    assign br_target     = Pc4 + {Ext_imm[WORD_W-3:0], 2'b00};
    assign j_target      = {Pc4[WORD_W-1:WORD_W-4], Jaddr, 2'b00};

    always_comb begin
        next_pc = j_target;
        case (Pcsrc)
            PCSRC_SEQ:    next_pc = Pc4;
            PCSRC_BRANCH: next_pc = br_target;
            default:      next_pc = j_target;  // 01 and 11 both jump
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch FSM with req/ready imem handshake.
// Define FETCH_PERF_CNT_EN to add retired/redirect counter outputs.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               Clk,
    input  logic               Clrn,
    input  logic [1:0]         Pcsrc,
    input  logic [WORD_W-1:0]  Ext_imm,
    input  logic [JADDR_W-1:0] Jaddr,
    input  logic               Stall,
    input  logic               Inst_ack,
    output logic               Imem_req,
    output logic [WORD_W-1:0]  Imem_addr,
    input  logic               Imem_ready,
    input  logic [WORD_W-1:0]  Imem_rdata,
    output logic [WORD_W-1:0]  Inst,
    output logic               Inst_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [WORD_W-1:0]  Cnt_retired,
    output logic [WORD_W-1:0]  Cnt_redirect,
`endif
    output logic [WORD_W-1:0]  Pc,
    output logic [WORD_W-1:0]  Pc4
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] next_pc;
    logic              retire;

    assign pc4    = pc_q + WORD_W'(4);
    assign retire = (state_q == FS_HOLD) && Inst_ack && !Stall;

    next_pc_calc u_next_pc (
        .Pc4     (pc4),
        .Ext_imm (Ext_imm),
        .Jaddr   (Jaddr),
        .Pcsrc   (Pcsrc),
        .next_pc (next_pc)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q      <= FS_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            FS_IDLE: state_d = FS_FETCH;
            FS_FETCH: begin
                if (Imem_ready) begin
                    inst_d       = Imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (retire) begin
                    pc_d         = next_pc;
                    inst_valid_d = 1'b0;
                    state_d      = FS_FETCH;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // Request is a pure state decode so Imem_ready never reaches it.
    assign Imem_req   = (state_q == FS_FETCH);
    assign Imem_addr  = pc_q;
    assign Inst       = inst_q;
    assign Inst_valid = inst_valid_q;
    assign Pc         = pc_q;
    assign Pc4        = pc4;

`ifdef FETCH_PERF_CNT_EN
    logic [WORD_W-1:0] cnt_retired_q, cnt_retired_d;
    logic [WORD_W-1:0] cnt_redirect_q, cnt_redirect_d;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            cnt_retired_q  <= '0;
            cnt_redirect_q <= '0;
        end else begin
            cnt_retired_q  <= cnt_retired_d;
            cnt_redirect_q <= cnt_redirect_d;
        end
    end

    always_comb begin
        cnt_retired_d  = cnt_retired_q;
        cnt_redirect_d = cnt_redirect_q;
        if (retire) begin
            cnt_retired_d = cnt_retired_q + WORD_W'(1);
            if (Pcsrc != PCSRC_SEQ)
                cnt_redirect_d = cnt_redirect_q + WORD_W'(1);
        end
    end

    assign Cnt_retired  = cnt_retired_q;
    assign Cnt_redirect = cnt_redirect_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: transaction-level model checked every cycle plus literal pins.
module tb_pc_fetch_unit;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b0;
    logic [1:0]  Pcsrc = 2'b00;
    logic [31:0] Ext_imm = 32'h0;
    logic [25:0] Jaddr = 26'h0;
    logic        Stall = 1'b0;
    logic        Inst_ack = 1'b0;
    logic        Imem_ready = 1'b0;
    logic [31:0] Imem_rdata = 32'h0;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic [31:0] Inst;
    logic        Inst_valid;
    logic [31:0] Pc;
    logic [31:0] Pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] Cnt_retired;
    logic [31:0] Cnt_redirect;
`endif

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk        (Clk),
        .Clrn       (Clrn),
        .Pcsrc      (Pcsrc),
        .Ext_imm    (Ext_imm),
        .Jaddr      (Jaddr),
        .Stall      (Stall),
        .Inst_ack   (Inst_ack),
        .Imem_req   (Imem_req),
        .Imem_addr  (Imem_addr),
        .Imem_ready (Imem_ready),
        .Imem_rdata (Imem_rdata),
        .Inst       (Inst),
        .Inst_valid (Inst_valid),
`ifdef FETCH_PERF_CNT_EN
        .Cnt_retired  (Cnt_retired),
        .Cnt_redirect (Cnt_redirect),
`endif
        .Pc         (Pc),
        .Pc4        (Pc4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural next PC straight from the ISA rules.
    function automatic logic [31:0] target(input logic [31:0] pc, input logic [1:0] src,
                                           input logic [31:0] imm, input logic [25:0] ja);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (src == 2'b00) return seq;
        if (src == 2'b10) return seq + imm * 32'd4;
        return (seq & 32'hF000_0000) | ({6'b0, ja} * 32'd4);
    endfunction

    // Model: one dead cycle after reset, then alternate waiting-for-memory / holding-instruction.
    logic        m_idle = 1'b1;
    logic        m_req = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ret = 32'h0;
    logic [31:0] m_redir = 32'h0;

    always @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            m_idle <= 1'b1; m_req <= 1'b0; m_valid <= 1'b0; m_inst <= 32'h0;
            m_pc <= 32'h0; m_ret <= 32'h0; m_redir <= 32'h0;
        end else if (m_idle) begin
            m_idle <= 1'b0; m_req <= 1'b1;
        end else if (m_req) begin
            if (Imem_ready) begin
                m_inst <= Imem_rdata; m_valid <= 1'b1; m_req <= 1'b0;
            end
        end else if (m_valid && Inst_ack && !Stall) begin
            m_pc    <= target(m_pc, Pcsrc, Ext_imm, Jaddr);
            m_ret   <= m_ret + 32'd1;
            m_redir <= m_redir + ((Pcsrc != 2'b00) ? 32'd1 : 32'd0);
            m_valid <= 1'b0;
            m_req   <= 1'b1;
        end
    end

    always @(negedge Clk) begin
        chk("m_req",   32'(Imem_req),   32'(m_req));
        chk("m_valid", 32'(Inst_valid), 32'(m_valid));
        chk("m_pc",    Pc,        m_pc);
        chk("m_addr",  Imem_addr, m_pc);
        chk("m_pc4",   Pc4,       m_pc + 32'd4);
        if (m_valid || !Clrn) chk("m_inst", Inst, m_inst);
`ifdef FETCH_PERF_CNT_EN
        chk("m_cnt_ret",   Cnt_retired,  m_ret);
        chk("m_cnt_redir", Cnt_redirect, m_redir);
`endif
    end

    task automatic step();
        @(negedge Clk);
    endtask

    // Entered at a negedge with the unit in FETCH at address a.
    task automatic fetch(input logic [31:0] w, input int lat, input logic [31:0] a);
        for (int i = 0; i < lat - 1; i++) begin
            Imem_ready = 1'b0;
            Imem_rdata = $urandom;
            step();
            chk("wait_req",  32'(Imem_req), 32'd1);
            chk("wait_addr", Imem_addr, a);
        end
        Imem_ready = 1'b1;
        Imem_rdata = w;
        step();
        Imem_ready = 1'b0;
        chk("fetch_inst",  Inst, w);
        chk("fetch_valid", 32'(Inst_valid), 32'd1);
        chk("fetch_req",   32'(Imem_req), 32'd0);
    endtask

    // Entered at a negedge in HOLD; stalls for nst cycles with ack high, then retires.
    task automatic retire(input logic [1:0] src, input logic [31:0] imm, input logic [25:0] ja,
                          input int nst, input logic [31:0] pc_before, input logic [31:0] pc_after);
        Inst_ack = 1'b1; Pcsrc = src; Ext_imm = imm; Jaddr = ja;
        Stall = 1'b1;
        for (int i = 0; i < nst; i++) begin
            step();
            chk("stall_pc",    Pc, pc_before);
            chk("stall_valid", 32'(Inst_valid), 32'd1);
        end
        Stall = 1'b0;
        step();
        Inst_ack = 1'b0; Pcsrc = 2'($urandom); Ext_imm = $urandom; Jaddr = 26'($urandom);
        chk("ret_pc",    Pc, pc_after);
        chk("ret_valid", 32'(Inst_valid), 32'd0);
        chk("ret_req",   32'(Imem_req), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        Imem_ready = 1'b1;             // ignored while in reset and in IDLE
        Imem_rdata = 32'h2008_0005;
        repeat (3) step();
        chk("rst_req",   32'(Imem_req), 32'd0);
        chk("rst_valid", 32'(Inst_valid), 32'd0);
        chk("rst_pc",    Pc, 32'h0);
        chk("rst_inst",  Inst, 32'h0);
        Clrn = 1'b1;
        step();
        chk("first_req",  32'(Imem_req), 32'd1);
        chk("first_addr", Imem_addr, 32'h0);
        step();
        Imem_ready = 1'b0;
        chk("first_inst",  Inst, 32'h2008_0005);
        chk("first_valid", 32'(Inst_valid), 32'd1);

        retire(2'b00, 32'h0, 26'h0, 0, 32'h0, 32'h4);
        fetch(32'h1111_0001, 1, 32'h4);
        retire(2'b10, 32'h2, 26'h0, 0, 32'h4, 32'h10);
        fetch(32'h1111_0002, 2, 32'h10);
        retire(2'b10, 32'hFFFF_FFFE, 26'h0, 0, 32'h10, 32'h0C);
        fetch(32'h1111_0003, 1, 32'h0C);
        retire(2'b10, 32'h0FFF_FFFC, 26'h0, 0, 32'h0C, 32'h4000_0000);
        fetch(32'h1111_0004, 3, 32'h4000_0000);
        retire(2'b01, 32'h1234_5678, 26'h000_0040, 2, 32'h4000_0000, 32'h4000_0100);
        fetch(32'h1111_0005, 1, 32'h4000_0100);
        retire(2'b11, 32'h0, 26'h3FF_FFFF, 0, 32'h4000_0100, 32'h4FFF_FFFC);
        fetch(32'h1111_0006, 2, 32'h4FFF_FFFC);
        retire(2'b10, 32'hEBFF_FFFF, 26'h0, 1, 32'h4FFF_FFFC, 32'hFFFF_FFFC);
        fetch(32'h1111_0007, 1, 32'hFFFF_FFFC);
        retire(2'b00, 32'h0, 26'h0, 0, 32'hFFFF_FFFC, 32'h0);
        fetch(32'h1111_0008, 1, 32'h0);
        retire(2'b00, 32'h0, 26'h0, 0, 32'h0, 32'h4);

        // Reset in the middle of a FETCH cycle, with ready arriving during reset.
        #2;
        Clrn = 1'b0;
        Imem_ready = 1'b1;
        Imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("mf_rst_req", 32'(Imem_req), 32'd0);
        chk("mf_rst_pc",  Pc, 32'h0);
        step();
        step();
        chk("mf_rst_inst",  Inst, 32'h0);
        chk("mf_rst_valid", 32'(Inst_valid), 32'd0);
        Imem_ready = 1'b0;
        Clrn = 1'b1;
        step();
        chk("mf_rel_req", 32'(Imem_req), 32'd1);

        fetch(32'h2222_0001, 1, 32'h0);
        retire(2'b00, 32'h0, 26'h0, 0, 32'h0, 32'h4);
        fetch(32'h2222_0002, 2, 32'h4);
        retire(2'b10, 32'h3, 26'h0, 0, 32'h4, 32'h14);
        fetch(32'h2222_0003, 1, 32'h14);
        retire(2'b00, 32'h0, 26'h0, 1, 32'h14, 32'h18);
        fetch(32'h2222_0004, 1, 32'h18);
        retire(2'b01, 32'h0, 26'h000_0100, 0, 32'h18, 32'h400);
        fetch(32'h2222_0005, 1, 32'h400);
        retire(2'b00, 32'h0, 26'h0, 0, 32'h400, 32'h404);
        fetch(32'h2222_0006, 1, 32'h404);
`ifdef FETCH_PERF_CNT_EN
        chk("cnt_retired",  Cnt_retired,  32'd5);
        chk("cnt_redirect", Cnt_redirect, 32'd2);
`endif

        // Reset in the middle of a HOLD cycle.
        #2;
        Clrn = 1'b0;
        #1;
        chk("mh_rst_valid", 32'(Inst_valid), 32'd0);
        chk("mh_rst_inst",  Inst, 32'h0);
        chk("mh_rst_pc",    Pc, 32'h0);
        chk("mh_rst_req",   32'(Imem_req), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("mh_rst_cnt_ret",   Cnt_retired,  32'd0);
        chk("mh_rst_cnt_redir", Cnt_redirect, 32'd0);
`endif
        step();
        Clrn = 1'b1;
        step();
        chk("mh_rel_req", 32'(Imem_req), 32'd1);
        fetch(32'h3333_0001, 2, 32'h0);
        retire(2'b00, 32'h0, 26'h0, 0, 32'h0, 32'h4);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
